// File: rtl/s_term_cfg_pkg.sv
// Shared constants for the S_term configuration frame-strobe controller.
// The FSM encodings are plain constants so older netlists can keep using them.
package s_term_cfg_pkg;

  localparam int FRAME_IDX_W    = 5;
  localparam int FRAME_CNT_W    = 16;
  localparam int DEF_MAX_FRAMES = 20;
  localparam int TIMER_W        = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETUP  = 2'd1;
  localparam state_t ST_STROBE = 2'd2;
  localparam state_t ST_HOLD   = 2'd3;

  function automatic logic [FRAME_CNT_W-1:0] sat_inc(input logic [FRAME_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cfg_cycle_timer.sv
// Loadable down-counter with a zero flag.
// Used to time both the SETUP and the STROBE phases of a frame write.
module cfg_cycle_timer #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // The counter parks at zero until it is reloaded.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/s_term_frame_strobe_ctrl.sv
// Per-column frame-strobe controller in the S_term tile.
// Matches frame-write requests to this column and drives a timed one-hot FrameStrobe pulse.
module s_term_frame_strobe_ctrl
  import s_term_cfg_pkg::*;
#(
  parameter int COL_ID     = 0,
  parameter int COL_W      = 6,
  parameter int MAX_FRAMES = DEF_MAX_FRAMES,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2
) (
  input  logic                   CLK,
  input  logic                   resetn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [COL_W-1:0]       req_col,
  input  logic [FRAME_IDX_W-1:0] req_frame,
  input  logic                   err_clr,
  output logic [MAX_FRAMES-1:0]  FrameStrobe_O,
  output logic                   done,
  output logic                   err,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int SETUP_LD  = (SETUP_CYC > 0) ? SETUP_CYC - 1 : 0;
  localparam int STROBE_LD = STROBE_CYC - 1;

  state_t                 state_q, state_d;
  logic [FRAME_IDX_W-1:0] idx_q, idx_d;
  logic                   err_q, err_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [MAX_FRAMES-1:0]  strobe_q, strobe_d;
  logic                   done_q, done_d;

  logic               accept;
  logic               col_hit;
  logic               range_ok;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_zero;

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid & req_ready;
  assign col_hit   = (req_col == COL_W'(COL_ID));
  assign range_ok  = (32'(req_frame) < MAX_FRAMES);

  cfg_cycle_timer #(
    .W(TIMER_W)
  ) u_timer (
    .CLK      (CLK),
    .resetn   (resetn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Strobe and done are decoded from the next state so both come straight from flops.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    err_d       = err_q;
    frame_cnt_d = frame_cnt_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    if (err_clr) begin
      err_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept && col_hit) begin
          if (!range_ok) begin
            err_d = 1'b1;
          end else begin
            idx_d    = req_frame;
            tmr_load = 1'b1;
            if (SETUP_CYC == 0) begin
              state_d = ST_STROBE;
              tmr_val = TIMER_W'(STROBE_LD);
            end else begin
              state_d = ST_SETUP;
              tmr_val = TIMER_W'(SETUP_LD);
            end
          end
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          state_d  = ST_STROBE;
          tmr_load = 1'b1;
          tmr_val  = TIMER_W'(STROBE_LD);
        end
      end
      ST_STROBE: begin
        if (tmr_zero) begin
          state_d     = ST_HOLD;
          frame_cnt_d = sat_inc(frame_cnt_q);
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    strobe_d = (state_d == ST_STROBE) ? (MAX_FRAMES'(1) << idx_d) : '0;
    done_d   = (state_d == ST_HOLD);
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      strobe_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      strobe_q    <= strobe_d;
      done_q      <= done_d;
    end
  end

  assign FrameStrobe_O = strobe_q;
  assign done          = done_q;
  assign err           = err_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_s_term_frame_strobe_ctrl.sv
// Directed bench for s_term_frame_strobe_ctrl with a strobe scoreboard on the default instance.
// A second instance covers the zero-setup, single-cycle-strobe configuration.
module tb_s_term_frame_strobe_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic resetn;

  logic        a_valid, a_ready, a_err_clr, a_done, a_err;
  logic [5:0]  a_col;
  logic [4:0]  a_frame;
  logic [19:0] a_strobe;
  logic [15:0] a_cnt;

  logic        b_valid, b_ready, b_err_clr, b_done, b_err;
  logic [5:0]  b_col;
  logic [4:0]  b_frame;
  logic [19:0] b_strobe;
  logic [15:0] b_cnt;

  int checks = 0;
  int errors = 0;

  logic [19:0] exp_q[$];
  logic [19:0] prev_a = '0;

  s_term_frame_strobe_ctrl #(
    .COL_ID(3), .COL_W(6), .MAX_FRAMES(20), .SETUP_CYC(1), .STROBE_CYC(2)
  ) dut_a (
    .CLK(CLK), .resetn(resetn), .req_valid(a_valid), .req_ready(a_ready),
    .req_col(a_col), .req_frame(a_frame), .err_clr(a_err_clr),
    .FrameStrobe_O(a_strobe), .done(a_done), .err(a_err), .frame_cnt(a_cnt)
  );

  s_term_frame_strobe_ctrl #(
    .COL_ID(3), .COL_W(6), .MAX_FRAMES(20), .SETUP_CYC(0), .STROBE_CYC(1)
  ) dut_b (
    .CLK(CLK), .resetn(resetn), .req_valid(b_valid), .req_ready(b_ready),
    .req_col(b_col), .req_frame(b_frame), .err_clr(b_err_clr),
    .FrameStrobe_O(b_strobe), .done(b_done), .err(b_err), .frame_cnt(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge CLK);
  endtask

  // Handshake in one cycle, then scramble the fields to show they are ignored.
  task automatic apply_req(input logic [5:0] col, input logic [4:0] frame);
    @(negedge CLK);
    chk("ready_at_accept", a_ready, 1);
    a_valid = 1'b1;
    a_col   = col;
    a_frame = frame;
    @(negedge CLK);
    a_valid = 1'b0;
    a_col   = 6'($urandom);
    a_frame = 5'($urandom);
  endtask

  // Scoreboard: every rising strobe on dut_a must match the oldest queued frame.
  always @(negedge CLK) begin
    chk("strobe_onehot", 32'($onehot0(a_strobe)), 1);
    if (a_strobe != '0 && prev_a == '0) begin
      if (exp_q.size() == 0) begin
        chk("strobe_unexpected", a_strobe, 0);
      end else begin
        chk("strobe_frame", a_strobe, exp_q.pop_front());
      end
    end
    prev_a = a_strobe;
  end

  initial begin
    resetn    = 1'b0;
    a_valid   = 1'b0; a_col = '0; a_frame = '0; a_err_clr = 1'b0;
    b_valid   = 1'b0; b_col = '0; b_frame = '0; b_err_clr = 1'b0;
    nxt(); nxt();
    resetn = 1'b1;
    nxt();
    chk("rst_ready", a_ready, 1);
    chk("rst_strobe", a_strobe, 0);
    chk("rst_done", a_done, 0);
    chk("rst_err", a_err, 0);
    chk("rst_cnt", a_cnt, 0);

    // Matching request, frame 7: strobe T+2..T+3, done T+4, ready T+5
    exp_q.push_back(20'h1 << 7);
    apply_req(6'd3, 5'd7);
    chk("t1_strobe", a_strobe, 0);
    chk("t1_ready", a_ready, 0);
    nxt();
    chk("t2_strobe", a_strobe, 20'h1 << 7);
    chk("t2_done", a_done, 0);
    nxt();
    chk("t3_strobe", a_strobe, 20'h1 << 7);
    nxt();
    chk("t4_strobe", a_strobe, 0);
    chk("t4_done", a_done, 1);
    chk("t4_ready", a_ready, 0);
    nxt();
    chk("t5_ready", a_ready, 1);
    chk("t5_done", a_done, 0);
    chk("t5_cnt", a_cnt, 1);

    // Other column: dropped, accepted every cycle
    a_valid = 1'b1; a_col = 6'd2; a_frame = 5'd7;
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("drop_ready", a_ready, 1);
      chk("drop_strobe", a_strobe, 0);
      chk("drop_done", a_done, 0);
    end
    a_valid = 1'b0;
    nxt();
    chk("drop_cnt", a_cnt, 1);
    chk("drop_err", a_err, 0);

    // Out-of-range frame sets err, then clear, then clear coincident with new error
    apply_req(6'd3, 5'd20);
    chk("oor_err", a_err, 1);
    chk("oor_ready", a_ready, 1);
    nxt();
    chk("oor_strobe", a_strobe, 0);
    chk("oor_done", a_done, 0);
    chk("oor_err_hold", a_err, 1);
    a_err_clr = 1'b1;
    nxt();
    a_err_clr = 1'b0;
    chk("errclr", a_err, 0);
    a_err_clr = 1'b1; a_valid = 1'b1; a_col = 6'd3; a_frame = 5'd31;
    nxt();
    a_err_clr = 1'b0; a_valid = 1'b0;
    chk("err_set_wins", a_err, 1);
    a_err_clr = 1'b1;
    nxt();
    a_err_clr = 1'b0;
    chk("errclr2", a_err, 0);

    // Highest legal frame
    exp_q.push_back(20'h1 << 19);
    apply_req(6'd3, 5'd19);
    nxt();
    chk("f19_strobe", a_strobe, 20'h1 << 19);
    nxt(); nxt();
    chk("f19_done", a_done, 1);
    nxt();
    chk("f19_cnt", a_cnt, 2);
    chk("f19_err", a_err, 0);

    // Zero-setup, single-cycle strobe instance
    @(negedge CLK);
    chk("b_ready0", b_ready, 1);
    b_valid = 1'b1; b_col = 6'd3; b_frame = 5'd0;
    nxt();
    b_valid = 1'b0; b_frame = 5'd9;
    chk("b_t1_strobe", b_strobe, 20'h1);
    chk("b_t1_ready", b_ready, 0);
    nxt();
    chk("b_t2_strobe", b_strobe, 0);
    chk("b_t2_done", b_done, 1);
    nxt();
    chk("b_t3_ready", b_ready, 1);
    chk("b_t3_done", b_done, 0);
    chk("b_cnt", b_cnt, 1);

    // Asynchronous reset while strobing
    exp_q.push_back(20'h1 << 5);
    apply_req(6'd3, 5'd5);
    nxt();
    chk("rs_strobe_before", a_strobe, 20'h1 << 5);
    #1 resetn = 1'b0;
    #1;
    chk("rs_strobe", a_strobe, 0);
    chk("rs_done", a_done, 0);
    chk("rs_cnt", a_cnt, 0);
    chk("rs_ready", a_ready, 1);
    @(negedge CLK);
    resetn = 1'b1;
    exp_q.push_back(20'h1 << 11);
    apply_req(6'd3, 5'd11);
    nxt();
    chk("post_rs_strobe", a_strobe, 20'h1 << 11);
    nxt(); nxt();
    chk("post_rs_done", a_done, 1);
    nxt();
    chk("post_rs_cnt", a_cnt, 1);

    // Counter saturation
    force dut_a.frame_cnt_q = 16'hFFFF;
    nxt();
    release dut_a.frame_cnt_q;
    nxt();
    chk("sat_preload", a_cnt, 16'hFFFF);
    exp_q.push_back(20'h1 << 1);
    apply_req(6'd3, 5'd1);
    nxt(); nxt(); nxt();
    chk("sat_done", a_done, 1);
    nxt();
    chk("sat_cnt", a_cnt, 16'hFFFF);

    nxt();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/s_term_frame_strobe_ctrl.md
# s_term_frame_strobe_ctrl

Per-column configuration frame-strobe controller in the bottom terminal (S_term) tile. Accepts frame-write requests from the fabric configuration port, matches them against its own column, and drives a timed one-hot pulse on that column's `FrameStrobe` bus, which travels north through every tile of the column. `FrameData` for the target frame is supplied by the row-wise data path and must already be stable; this block sequences only setup, strobe and hold timing around it.

## Interface
Parameters:
- `COL_ID`, 0: column index this instance answers to.
- `COL_W`, 6: width of the column-select field.
- `MAX_FRAMES`, 20: frames per column; width of `FrameStrobe_O`.
- `SETUP_CYC`, 1: cycles between request accept and strobe assertion (0 allowed).
- `STROBE_CYC`, 2: strobe pulse width in cycles (≥1).

Ports (one clock; reset is asynchronous and active-low):
- `CLK`  in  1  configuration clock.
- `resetn`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  frame-write request valid.
- `req_ready`  out  1  controller can accept a request.
- `req_col`  in  COL_W  target column.
- `req_frame`  in  5  target frame index within the column.
- `err_clr`  in  1  clears sticky error.
- `FrameStrobe_O`  out  MAX_FRAMES  one-hot strobe bus to the column, registered.
- `done`  out  1  one-cycle pulse when a strobe sequence completes.
- `err`  out  1  sticky flag: out-of-range frame index was addressed to this column.
- `frame_cnt`  out  16  frames strobed since reset, saturating at 0xFFFF.

## Operation
- States: IDLE, SETUP, STROBE, HOLD. Reset → IDLE; all outputs 0 except `req_ready`=1.
- `req_ready` = 1 only in IDLE. Handshake = `req_valid & req_ready`.
- On accept, `req_col != COL_ID`: request dropped, stays IDLE, no `done`, no counter change.
- On accept, `req_col == COL_ID` and `req_frame >= MAX_FRAMES`: `err` set next cycle, stays IDLE, no strobe, no `done`.
- On accept, match and in range: latch index; go SETUP (or STROBE directly if `SETUP_CYC`=0).
- SETUP: down-counter runs `SETUP_CYC` cycles → STROBE.
- STROBE: `FrameStrobe_O[idx]`=1 for exactly `STROBE_CYC` cycles; all other bits 0 → HOLD.
- HOLD: 1 cycle, strobe 0, `done`=1, `frame_cnt` increments (saturating) → IDLE.
- `err_clr` and new error in same cycle: set wins. `err` otherwise holds until `err_clr`.
- `FrameStrobe_O` is never multi-hot; a register glitch-free output.
- Request fields ignored outside the handshake cycle.

## Timing
- Accept at cycle T: strobe high cycles T+1+SETUP_CYC … T+SETUP_CYC+STROBE_CYC; `done` at T+SETUP_CYC+STROBE_CYC+1; `req_ready` high again at T+SETUP_CYC+STROBE_CYC+2.
- Defaults: strobe at T+2..T+3, `done` at T+4, next accept at T+5 earliest.
- Dropped/error requests: `req_ready` stays 1; back-to-back accepts every cycle.
- `resetn` low mid-sequence: strobe, `done` clear immediately (asynchronous); `frame_cnt`, `err` clear; IDLE on release.

## Structure
- Package `s_term_cfg_pkg`: state enum, `FRAME_IDX_W`=5, `FRAME_CNT_W`=16, default `MAX_FRAMES`.
- One sub-module `cfg_cycle_timer`: loadable down-counter with zero flag, shared by SETUP and STROBE phases.

## Test plan
- COL_ID=3, defaults; accept {col 3, frame 7} at T=10 → `FrameStrobe_O`=1<<7 at cycles 12–13, `done` at 14, `frame_cnt`=1, `req_ready` at 15.
- {col 2, frame 7} → no strobe, no `done`, `req_ready` stays 1, `frame_cnt` unchanged.
- {col 3, frame 20} → `err`=1 next cycle, no strobe; pulse `err_clr` → `err`=0; `err_clr` coincident with new error → `err`=1.
- SETUP_CYC=0, STROBE_CYC=1; accept frame 0 at T → strobe bit 0 at T+1 only, `done` at T+2.
- `resetn` asserted during STROBE → `FrameStrobe_O`=0 same cycle, `frame_cnt`=0; on release a new request completes normally.
- Preload 0xFFFF strobes (force counter) then one more → `frame_cnt` stays 0xFFFF.
